// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants for the CORDIC rotator / vectoring pair.
//   ANGLE_FRAC      : fractional bits of the angle format (Q3.14 radians)
//   PI_Q, HALF_PI_Q : pi and pi/2 in that format
//   CORDIC_GAIN_INV : 1/K pre-scale the rotator applies (16384 = 1.0)
//   ATAN_TABLE      : atan(2^-i) in Q3.14, rounded, i = 0..15
//   cordic_state_t  : sequencing states of the iterative engines
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int ANGLE_FRAC      = 14;
    localparam int PI_Q            = 51472;
    localparam int HALF_PI_Q       = 25736;
    localparam int CORDIC_GAIN_INV = 9949;

    localparam int ATAN_DEPTH = 16;
    localparam int ATAN_IDX_W = 4;

    localparam int ATAN_TABLE [ATAN_DEPTH] = '{
        12868, 7596, 4014, 2037, 1023, 512, 256, 128,
        64,    32,   16,   8,    4,    2,   1,   1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ROT  = 2'd2,
        ST_DONE = 2'd3
    } cordic_state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// -----------------------------------------------------------------------------
// cordic_atan_rom
// Combinational lookup of the micro-rotation angle atan(2^-idx).
//   idx  : iteration index, 0..15
//   atan : angle in Q3.14 radians, sign-extended to AW bits
// -----------------------------------------------------------------------------
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int AW = 19
) (
    input  logic [ATAN_IDX_W-1:0] idx,
    output logic signed [AW-1:0]  atan
);

    logic signed [AW-1:0] table_w [ATAN_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < ATAN_DEPTH; gi++) begin : g_table
            assign table_w[gi] = AW'(ATAN_TABLE[gi]);
        end
    endgenerate

    assign atan = table_w[idx];

endmodule

// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
// Iterative vectoring-mode CORDIC: drives y to zero and returns the
// accumulated angle atan2(y, x) together with the gained magnitude.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request pulse, sampled only while idle
//   x_in/y_in : signed Cartesian input (IW bits)
//   busy      : operation in progress (from the cycle after acceptance)
//   done      : one-cycle pulse when mag_out/phase_out are updated
//   mag_out   : K*sqrt(x^2+y^2), K ~ 1.64676, unsigned IW+2 bits
//   phase_out : atan2(y, x), Q3.14 radians, clamped to +/-pi
// Latency: start accepted at edge N -> done visible after edge N+ITER+2.
// -----------------------------------------------------------------------------
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int IW   = 16,
    parameter int GW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [IW-1:0] x_in,
    input  logic signed [IW-1:0] y_in,
    output logic                 busy,
    output logic                 done,
    output logic [IW+1:0]        mag_out,
    output logic signed [IW:0]   phase_out
);

    // x/y carry guard bits so that the fold of -2^(IW-1) and the CORDIC
    // growth (up to K*sqrt(2)) stay representable.
    localparam int XW = IW + GW;
    // Angle accumulator: +/-pi plus the full table sum fits in 19 bits.
    localparam int ZW = ANGLE_FRAC + 5;

    localparam logic signed [ZW-1:0] PI_Z     = ZW'(PI_Q);
    localparam logic signed [ZW-1:0] NEG_PI_Z = -ZW'(PI_Q);
    localparam logic signed [IW:0]   PI_P     = (IW + 1)'(PI_Q);
    localparam logic signed [IW:0]   NEG_PI_P = -((IW + 1)'(PI_Q));
    localparam logic [ATAN_IDX_W-1:0] LAST_IDX = ATAN_IDX_W'(ITER - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cordic_state_t state_reg, state_next;

    logic signed [XW-1:0]   x_reg, y_reg;
    logic signed [ZW-1:0]   z_reg;
    logic [ATAN_IDX_W-1:0]  iter_reg;
    logic                   zero_reg;
    logic                   done_reg;
    logic [IW+1:0]          mag_reg;
    logic signed [IW:0]     phase_reg;

    // Control strobes decoded from the state
    logic load_en, pre_en, rot_en, fin_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start) state_next = ST_PRE;
            ST_PRE:  state_next = ST_ROT;
            ST_ROT:  if (iter_reg == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        load_en = 1'b0;
        pre_en  = 1'b0;
        rot_en  = 1'b0;
        fin_en  = 1'b0;
        busy    = 1'b0;
        unique case (state_reg)
            ST_IDLE: load_en = start;
            ST_PRE:  begin pre_en = 1'b1; busy = 1'b1; end
            ST_ROT:  begin rot_en = 1'b1; busy = 1'b1; end
            ST_DONE: begin fin_en = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Micro-rotation datapath
    // ------------------------------------------------------------------
    logic signed [ZW-1:0] atan_i;
    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] x_rot, y_rot;
    logic signed [ZW-1:0] z_rot;

    cordic_atan_rom #(
        .AW (ZW)
    ) u_atan_rom (
        .idx  (iter_reg),
        .atan (atan_i)
    );

    assign x_sh = x_reg >>> iter_reg;
    assign y_sh = y_reg >>> iter_reg;

    // Rotate toward the x axis: the sign of y picks the direction.
    always_comb begin
        if (!y_reg[XW-1]) begin
            x_rot = x_reg + y_sh;
            y_rot = y_reg - x_sh;
            z_rot = z_reg + atan_i;
        end else begin
            x_rot = x_reg - y_sh;
            y_rot = y_reg + x_sh;
            z_rot = z_reg - atan_i;
        end
    end

    // Final phase: the residual table error can push z just past +/-pi.
    logic signed [IW:0] phase_sat;
    always_comb begin
        if (zero_reg) begin
            phase_sat = '0;
        end else if (z_reg > PI_Z) begin
            phase_sat = PI_P;
        end else if (z_reg < NEG_PI_Z) begin
            phase_sat = NEG_PI_P;
        end else begin
            phase_sat = z_reg[IW:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            zero_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mag_reg   <= '0;
            phase_reg <= '0;
        end else begin
            done_reg <= fin_en;

            if (load_en) begin
                x_reg    <= XW'(x_in);
                y_reg    <= XW'(y_in);
                zero_reg <= (x_in == '0) && (y_in == '0);
            end

            if (pre_en) begin
                iter_reg <= '0;
                if (x_reg[XW-1]) begin
                    // Left half-plane: rotate by pi. y still holds the
                    // original sample, so y == 0 folds to +pi.
                    x_reg <= -x_reg;
                    y_reg <= -y_reg;
                    z_reg <= y_reg[XW-1] ? NEG_PI_Z : PI_Z;
                end else begin
                    z_reg <= '0;
                end
            end

            if (rot_en) begin
                x_reg    <= x_rot;
                y_reg    <= y_rot;
                z_reg    <= z_rot;
                iter_reg <= iter_reg + 1'b1;
            end

            if (fin_en) begin
                mag_reg   <= zero_reg ? '0 : x_reg[IW+1:0];
                phase_reg <= phase_sat;
            end
        end
    end

    assign done      = done_reg;
    assign mag_out   = mag_reg;
    assign phase_out = phase_reg;

endmodule
